// File: rtl/fifo_pkg.sv
// Shared FIFO definitions, used by the synchronous FIFO here and by the async FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and depth.
//   MODE_STD / MODE_FWFT   : read-mode encodings for the FWFT parameter.
//   addr_width()           : ceil(log2(depth)), the memory address width.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Smallest w such that 2**w >= depth.
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port, no reset.
//   clk       : write clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data, combinational from rd_addr_i
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, level flags, sticky error flags and
// an optional first-word-fall-through read mode.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   wr_en, rd_en : write / read requests (ignored when full / empty)
//   clr_err      : clears overflow/underflow (a new error in the same cycle wins)
//   data_in      : write data
//   data_out     : read data (registered in standard mode, head-of-queue in FWFT)
//   full, empty, half_full, almost_full, almost_empty : decoded from count
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = MODE_STD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          clr_err,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          half_full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [addr_width(DEPTH):0]    count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  // Pointers carry one extra wrap bit above the memory address.
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_accept, rd_accept;
  logic [DATA_W-1:0] rd_data;

  // Flags depend only on registered state, never on this cycle's requests.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign half_full    = (count_q >= CNT_W'(DEPTH / 2));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_accept && !rd_accept) count_d = count_q + 1'b1;
    if (rd_accept && !wr_accept) count_d = count_q - 1'b1;

    // Setting has priority over clearing so an error in the clear cycle is kept.
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (data_in),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_data)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head of queue is shown directly; forced to zero while empty so the
      // output is defined after reset and never exposes stale memory.
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            dout_q <= '0;
        else if (rd_accept) dout_q <= rd_data;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_hf, s_af, s_ae, s_ovf, s_udf;
  logic          f_full, f_empty, f_hf, f_af, f_ae, f_ovf, f_udf;
  logic [4:0]    s_cnt, f_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err), .data_in(data_in),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .half_full(s_hf), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err), .data_in(data_in),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .half_full(f_hf), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_udf));

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: a queue of stored words plus sticky bits and the
  // standard-mode output register.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 0, m_udf = 0;
  logic [DW-1:0] m_dout = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf  = 0;
      m_udf  = 0;
      m_dout = '0;
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
      if (wr_en && was_full)  m_ovf = 1;
      if (rd_en && was_empty) m_udf = 1;
      if (rd_en && !was_empty) m_dout = mq.pop_front();
      if (wr_en && !was_full)  mq.push_back(data_in);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int n;
    int head;
    n    = mq.size();
    head = (n == 0) ? 0 : int'(mq[0]);
    chk("s_count", int'(s_cnt), n);          chk("f_count", int'(f_cnt), n);
    chk("s_full", int'(s_full), int'(n == DEPTH));   chk("f_full", int'(f_full), int'(n == DEPTH));
    chk("s_empty", int'(s_empty), int'(n == 0));     chk("f_empty", int'(f_empty), int'(n == 0));
    chk("s_half", int'(s_hf), int'(n >= DEPTH / 2)); chk("f_half", int'(f_hf), int'(n >= DEPTH / 2));
    chk("s_afull", int'(s_af), int'(n >= AF));       chk("f_afull", int'(f_af), int'(n >= AF));
    chk("s_aempty", int'(s_ae), int'(n <= AE));      chk("f_aempty", int'(f_ae), int'(n <= AE));
    chk("s_ovf", int'(s_ovf), int'(m_ovf));  chk("f_ovf", int'(f_ovf), int'(m_ovf));
    chk("s_udf", int'(s_udf), int'(m_udf));  chk("f_udf", int'(f_udf), int'(m_udf));
    chk("s_dout", int'(s_dout), int'(m_dout));
    chk("f_dout", int'(f_dout), head);
  end

  // Drive one cycle of requests at the falling edge; return just after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; clr_err = c; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_empty", int'(s_empty), 1);
    chk("rst_aempty", int'(s_ae), 1);
    chk("rst_dout", int'(s_dout), 0);

    // 1: fill with 0x01..0x10, watch thresholds, then overflow
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0, DW'(i));
      if (i == 7)  chk("t1_half7", int'(s_hf), 0);
      if (i == 8)  chk("t1_half8", int'(s_hf), 1);
      if (i == 13) chk("t1_af13", int'(s_af), 0);
      if (i == 14) chk("t1_af14", int'(s_af), 1);
      if (i == 15) chk("t1_full15", int'(s_full), 0);
    end
    chk("t1_full", int'(s_full), 1);
    chk("t1_cnt16", int'(s_cnt), 16);
    cyc(1, 0, 0, 8'h11);
    chk("t1_ovf", int'(s_ovf), 1);
    chk("t1_cnt_after_ovf", int'(s_cnt), 16);

    // 2: drain in order, underflow, clear
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, '0);
      chk("t2_std_data", int'(s_dout), i + 1);
      chk("t2_fwft_head", int'(f_dout), (i < 15) ? i + 2 : 0);
    end
    chk("t2_empty", int'(s_empty), 1);
    cyc(0, 1, 0, '0);
    chk("t2_udf", int'(s_udf), 1);
    chk("t2_dout_hold", int'(s_dout), 16);
    cyc(0, 0, 1, '0);
    chk("t2_clr_ovf", int'(s_ovf), 0);
    chk("t2_clr_udf", int'(s_udf), 0);

    // 3: steady count of 8 with simultaneous traffic across pointer wrap
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, DW'(8'h40 + k));
    for (int j = 0; j < 40; j++) begin
      cyc(1, 1, 0, DW'(8'h48 + j));
      chk("t3_cnt", int'(s_cnt), 8);
      chk("t3_order", int'(s_dout), 8'h40 + j);
    end
    for (int j = 0; j < 8; j++) cyc(0, 1, 0, '0);
    chk("t3_last", int'(s_dout), 8'h6F);

    // 4: FWFT fall-through of a single word
    cyc(1, 0, 0, 8'hA5);
    chk("t4_fwft_empty", int'(f_empty), 0);
    chk("t4_fwft_data", int'(f_dout), 8'hA5);
    cyc(0, 1, 0, '0);
    chk("t4_fwft_empty_after", int'(f_empty), 1);
    chk("t4_std_data", int'(s_dout), 8'hA5);

    // 5: simultaneous requests at full and at empty
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, DW'($urandom_range(0, 255)));
    cyc(1, 1, 0, 8'hEE);
    chk("t5_cnt15", int'(s_cnt), 15);
    chk("t5_ovf", int'(s_ovf), 1);
    for (int k = 0; k < 15; k++) cyc(0, 1, 0, '0);
    cyc(1, 1, 0, 8'h77);
    chk("t5_cnt1", int'(s_cnt), 1);
    chk("t5_udf", int'(s_udf), 1);
    chk("t5_fwft_head", int'(f_dout), 8'h77);
    cyc(0, 0, 1, '0);

    // 6: asynchronous reset mid-cycle with 5 words stored
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, DW'(8'h90 + k));
    chk("t6_cnt5", int'(s_cnt), 5);
    @(negedge clk);
    wr_en = 0; rd_en = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_cnt0", int'(s_cnt), 0);
    chk("t6_empty", int'(s_empty), 1);
    chk("t6_ae", int'(s_ae), 1);
    chk("t6_hf", int'(s_hf), 0);
    chk("t6_dout", int'(s_dout), 0);
    chk("t6_fwft_dout", int'(f_dout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 8'h3C);
    chk("t6_fwft_3c", int'(f_dout), 8'h3C);
    cyc(0, 1, 0, '0);
    chk("t6_std_3c", int'(s_dout), 8'h3C);

    // Randomized traffic, with phases biased toward filling and draining
    for (int c = 0; c < 3000; c++) begin
      int pw, pr;
      case ((c / 150) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 55; pr = 55; end
      endcase
      cyc(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
          DW'($urandom_range(0, 255)));
    end
    cyc(0, 0, 0, '0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
